// File: rtl/shf_ctl_if.sv
// shf_ctl_if: requester, shifter and response signals around shf_ctl
interface shf_ctl_if #(parameter int DATASIZE = 16);
  logic r0_req, r1_req, r0_gnt, r1_gnt;
  logic [1:0] r0_cls, r1_cls;
  logic [DATASIZE-1:0] r0_dtx, r1_dtx, r0_dty, r1_dty;
  logic ctl_shf_en;
  logic [1:0] ctl_shf_cls;
  logic [DATASIZE-1:0] ctl_dtx, ctl_dty;
  logic [DATASIZE-1:0] shf_xb_dt;
  logic shf_ps_sv, shf_ps_sz;
  logic rsp_vld, rsp_rdy, rsp_id;
  logic [DATASIZE-1:0] rsp_dt;
  logic rsp_sv, rsp_sz;
  logic [1:0] stk_sv, stk_clr;
  logic busy;
  modport slave (
    input  r0_req, r1_req, r0_cls, r1_cls, r0_dtx, r1_dtx, r0_dty, r1_dty,
    input  shf_xb_dt, shf_ps_sv, shf_ps_sz, rsp_rdy, stk_clr,
    output r0_gnt, r1_gnt, ctl_shf_en, ctl_shf_cls, ctl_dtx, ctl_dty,
    output rsp_vld, rsp_id, rsp_dt, rsp_sv, rsp_sz, stk_sv, busy
  );
  modport master (
    output r0_req, r1_req, r0_cls, r1_cls, r0_dtx, r1_dtx, r0_dty, r1_dty,
    output shf_xb_dt, shf_ps_sv, shf_ps_sz, rsp_rdy, stk_clr,
    input  r0_gnt, r1_gnt, ctl_shf_en, ctl_shf_cls, ctl_dtx, ctl_dty,
    input  rsp_vld, rsp_id, rsp_dt, rsp_sv, rsp_sz, stk_sv, busy
  );
endinterface

// File: rtl/shf_ctl.sv
// shf_ctl: round-robin issue controller sharing one shifter, with a one-entry response register
module shf_ctl #(parameter int DATASIZE = 16) (
  input logic clk,
  input logic reset,
  shf_ctl_if.slave bus
);
  logic infl_q, infl_d, infl_id_q, infl_id_d, prio_q, prio_d;
  logic rsp_vld_q, rsp_vld_d, rsp_id_q, rsp_id_d, rsp_sv_q, rsp_sv_d, rsp_sz_q, rsp_sz_d;
  logic [DATASIZE-1:0] rsp_dt_q, rsp_dt_d;
  logic [1:0] stk_q, stk_d, cls;
  logic drain, can_iss, cap, g0, g1, en;
  // grants gated by reset so nothing issues while the block is held in reset
  always_comb begin
    drain = !rsp_vld_q | bus.rsp_rdy;
    can_iss = reset & (!infl_q | drain);
    g0 = can_iss & bus.r0_req & (!bus.r1_req | !prio_q);
    g1 = can_iss & bus.r1_req & (!bus.r0_req | prio_q);
    en = g0 | g1;
    cap = infl_q & drain;
    cls = g1 ? bus.r1_cls : bus.r0_cls;
    infl_d = en | (infl_q & !cap);
    infl_id_d = en ? g1 : infl_id_q;
    prio_d = en ? !g1 : prio_q;
    rsp_vld_d = cap | (rsp_vld_q & !bus.rsp_rdy);
    rsp_id_d = cap ? infl_id_q : rsp_id_q;
    rsp_dt_d = cap ? bus.shf_xb_dt : rsp_dt_q;
    rsp_sv_d = cap ? bus.shf_ps_sv : rsp_sv_q;
    rsp_sz_d = cap ? bus.shf_ps_sz : rsp_sz_q;
    stk_d = (stk_q & ~bus.stk_clr) | ({1'b0, cap & bus.shf_ps_sv} << infl_id_q);
  end
  assign bus.r0_gnt = g0;
  assign bus.r1_gnt = g1;
  assign bus.ctl_shf_en = en;
  assign bus.ctl_shf_cls = cls;
  assign bus.ctl_dtx = g1 ? bus.r1_dtx : bus.r0_dtx;
  assign bus.ctl_dty = cls[1] ? '0 : (g1 ? bus.r1_dty : bus.r0_dty);
  assign bus.rsp_vld = rsp_vld_q;
  assign bus.rsp_id = rsp_id_q;
  assign bus.rsp_dt = rsp_dt_q;
  assign bus.rsp_sv = rsp_sv_q;
  assign bus.rsp_sz = rsp_sz_q;
  assign bus.stk_sv = stk_q;
  assign bus.busy = infl_q | rsp_vld_q;
  // pipeline, arbitration pointer, response and sticky state
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      infl_q <= 1'b0;
      infl_id_q <= 1'b0;
      prio_q <= 1'b0;
      rsp_vld_q <= 1'b0;
      rsp_id_q <= 1'b0;
      rsp_dt_q <= '0;
      rsp_sv_q <= 1'b0;
      rsp_sz_q <= 1'b0;
      stk_q <= '0;
    end else begin
      infl_q <= infl_d;
      infl_id_q <= infl_id_d;
      prio_q <= prio_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_id_q <= rsp_id_d;
      rsp_dt_q <= rsp_dt_d;
      rsp_sv_q <= rsp_sv_d;
      rsp_sz_q <= rsp_sz_d;
      stk_q <= stk_d;
    end
endmodule
